// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light timing controller.
package f1_pkg;

  localparam int unsigned LFSR_W  = 7;
  localparam int unsigned PRESC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ   = 2'd1,
    DELAY = 2'd2
  } f1_state_e;

  // One Fibonacci step of x^7+x^6+1: shift left, bit6 ^ bit5 into bit0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[6] ^ v[5]};
  endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// 7-bit maximal-length LFSR used as the random hold-delay source.
module f1_lfsr7
  import f1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  // Advance once per enabled cycle; an all-zero register escapes to 1 so it never locks up.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (q_q == '0) begin
        q_d = LFSR_W'(1);
      end else begin
        q_d = lfsr_next(q_q);
      end
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/f1_timing_ctrl.sv
// Tick generator and random hold-delay timer for the start-light sequence FSM.
module f1_timing_ctrl
  import f1_pkg::*;
#(
  parameter int unsigned       TICK_PERIOD = 48,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_seq,
  input  logic              cmd_delay,
  output logic              tick,
  output logic              time_out,
  output logic [LFSR_W-1:0] delay_val,
  output logic              busy
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_PERIOD - 1);

  f1_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [LFSR_W-1:0]  dcnt_q, dcnt_d;
  logic [LFSR_W-1:0]  dval_q, dval_d;
  logic               dly_prev_q, dly_prev_d;
  logic               tick_q, tick_d;
  logic               time_out_q, time_out_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               strobe;
  logic               dly_rise;

  f1_lfsr7 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign strobe   = (presc_q == PRESC_LAST);
  assign dly_rise = cmd_delay & ~dly_prev_q;

  // Next-state, prescaler, delay counter and strobe decode.
  // tick/time_out are registered from the strobe, so they appear one cycle after the
  // prescaler's last count; that lands exactly N*TICK_PERIOD cycles after state entry.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    dcnt_d     = dcnt_q;
    dval_d     = dval_q;
    dly_prev_d = dly_prev_q;
    tick_d     = 1'b0;
    time_out_d = 1'b0;
    if (en) begin
      dly_prev_d = cmd_delay;
      unique case (state_q)
        IDLE: begin
          if (dly_rise) begin
            dval_d  = lfsr_q;
            dcnt_d  = lfsr_q;
            state_d = DELAY;
          end else if (cmd_seq) begin
            state_d = SEQ;
          end
        end
        SEQ: begin
          if (dly_rise) begin
            dval_d  = lfsr_q;
            dcnt_d  = lfsr_q;
            state_d = DELAY;
          end else if (!cmd_seq) begin
            state_d = IDLE;
          end else if (strobe) begin
            tick_d = 1'b1;
          end
        end
        DELAY: begin
          if (!cmd_delay) begin
            state_d = IDLE;
          end else if (strobe) begin
            dcnt_d = dcnt_q - 7'd1;
            if (dcnt_q == 7'd1) begin
              time_out_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if ((state_d != state_q) || (state_d == IDLE) || strobe) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // All controller state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      dcnt_q     <= '0;
      dval_q     <= '0;
      dly_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      dcnt_q     <= dcnt_d;
      dval_q     <= dval_d;
      dly_prev_q <= dly_prev_d;
      tick_q     <= tick_d;
      time_out_q <= time_out_d;
    end
  end

  assign tick      = tick_q;
  assign time_out  = time_out_q;
  assign delay_val = dval_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_f1_timing_ctrl.sv
// Self-checking bench for f1_timing_ctrl with a cycle-level behavioural model.
module tb_f1_timing_ctrl;

  localparam int unsigned P    = 4;
  localparam logic [6:0]  SEED = 7'h01;
  localparam int M_IDLE  = 0;
  localparam int M_SEQ   = 1;
  localparam int M_DELAY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cmd_seq = 1'b0;
  logic       cmd_delay = 1'b0;
  logic       tick;
  logic       time_out;
  logic [6:0] delay_val;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: mode, enabled cycles spent in the mode, captured delay, LFSR, cmd_delay history.
  int          m_mode = M_IDLE;
  int unsigned m_age  = 0;
  int unsigned m_dv   = 0;
  int unsigned m_lfsr = 1;
  bit          m_prev = 1'b0;
  bit          m_tick = 1'b0;
  bit          m_to   = 1'b0;

  f1_timing_ctrl #(.TICK_PERIOD(P), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmd_seq   (cmd_seq),
    .cmd_delay (cmd_delay),
    .tick      (tick),
    .time_out  (time_out),
    .delay_val (delay_val),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int unsigned lfsr_adv(input int unsigned v);
    return ((v * 2) % 128) + (((v / 64) + (v / 32)) % 2);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit s, input bit d);
    bit rise;
    m_tick = 1'b0;
    m_to   = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_age = 0; m_dv = 0; m_lfsr = SEED; m_prev = 1'b0;
    end else if (e) begin
      rise = d && !m_prev;
      if (m_mode == M_IDLE) begin
        if (rise) begin m_dv = m_lfsr; m_mode = M_DELAY; m_age = 0; end
        else if (s) begin m_mode = M_SEQ; m_age = 0; end
      end else if (m_mode == M_SEQ) begin
        if (rise) begin m_dv = m_lfsr; m_mode = M_DELAY; m_age = 0; end
        else if (!s) m_mode = M_IDLE;
        else begin
          m_age++;
          if (m_age % P == 0) m_tick = 1'b1;
        end
      end else begin
        if (!d) m_mode = M_IDLE;
        else begin
          m_age++;
          if (m_age == m_dv * P) begin m_to = 1'b1; m_mode = M_IDLE; end
        end
      end
      m_prev = d;
      m_lfsr = lfsr_adv(m_lfsr);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit d);
    rst = r; en = e; cmd_seq = s; cmd_delay = d;
    @(posedge clk);
    model_edge(r, e, s, d);
    @(negedge clk);
    chk("tick", {15'd0, tick}, {15'd0, m_tick});
    chk("time_out", {15'd0, time_out}, {15'd0, m_to});
    chk("busy", {15'd0, busy}, {15'd0, (m_mode != M_IDLE)});
    chk("delay_val", {9'd0, delay_val}, 16'(m_dv));
  endtask

  task automatic wait_lfsr(input int unsigned v);
    int unsigned k = 0;
    while (m_lfsr != v && k < 130) begin
      step(0, 1, 0, 0);
      k++;
    end
    chk("lfsr_wait_bound", 16'(k < 130), 16'd1);
  endtask

  initial begin
    int unsigned k;
    int unsigned cnt;
    int unsigned first_tick;
    bit seen [128];
    bit s_lvl;
    bit d_lvl;

    // Reset state
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_lfsr", {9'd0, dut.lfsr_q}, 16'(SEED));
    chk("rst_busy", {15'd0, busy}, 16'd0);

    // Periodic ticks: entry cycle, then ticks at 4,8,12,16,20
    step(0, 1, 1, 0);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 1, 0);
      chk("seq_tick_sched", {15'd0, tick}, 16'(i % 4 == 0));
      chk("seq_busy", {15'd0, busy}, 16'd1);
      if (tick) cnt++;
    end
    chk("seq_tick_count", 16'(cnt), 16'd5);

    // Drop cmd_seq two cycles after the last tick
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("seq_exit_busy", {15'd0, busy}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      if (tick) cnt++;
    end
    chk("seq_exit_no_tick", 16'(cnt), 16'd0);

    // Delay of 5 ticks captured when LFSR = 5
    wait_lfsr(5);
    step(0, 1, 0, 1);
    chk("dv_is_5", {9'd0, delay_val}, 16'd5);
    k = 0;
    do begin
      step(0, 1, 0, 1);
      k++;
    end while (!time_out && k < 100);
    chk("delay_len", 16'(k), 16'd20);
    step(0, 1, 0, 0);

    // cmd_delay and cmd_seq rise together: delay wins, no ticks before time_out
    step(0, 1, 1, 1);
    chk("both_busy", {15'd0, busy}, 16'd1);
    cnt = 0; k = 0;
    while (!time_out && k < 600) begin
      step(0, 1, 1, 1);
      if (tick) cnt++;
      k++;
    end
    chk("both_timeout_seen", {15'd0, time_out}, 16'd1);
    chk("both_no_tick", 16'(cnt), 16'd0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // Abort 6 cycles into a 5-tick delay
    wait_lfsr(5);
    step(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, 0);
      if (time_out) cnt++;
    end
    chk("abort_no_timeout", 16'(cnt), 16'd0);

    // en low for 10 cycles mid-SEQ shifts the tick schedule by 10
    step(0, 1, 1, 0);
    for (int i = 1; i <= 6; i++) step(0, 1, 1, 0);
    for (int i = 7; i <= 16; i++) step(0, 0, 1, 0);
    first_tick = 0;
    for (int i = 17; i <= 30; i++) begin
      step(0, 1, 1, 0);
      if (tick && first_tick == 0) first_tick = i;
    end
    chk("pause_shift", 16'(first_tick), 16'd18);
    step(0, 1, 0, 0);

    // Reset in the middle of a delay
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    step(1, 1, 1, 1);
    chk("rst_mid_lfsr", {9'd0, dut.lfsr_q}, 16'(SEED));
    chk("rst_mid_dv", {9'd0, delay_val}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0);
      if (time_out) cnt++;
    end
    chk("rst_mid_no_timeout", 16'(cnt), 16'd0);

    // LFSR free-run: all 127 nonzero values exactly once
    step(1, 1, 0, 0);
    foreach (seen[i]) seen[i] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 127; i++) begin
      chk("lfsr_model", {9'd0, dut.lfsr_q}, 16'(m_lfsr));
      chk("lfsr_nonzero", 16'(dut.lfsr_q != 7'd0), 16'd1);
      if (!seen[dut.lfsr_q]) cnt++;
      seen[dut.lfsr_q] = 1'b1;
      step(0, 1, 0, 0);
    end
    chk("lfsr_distinct", 16'(cnt), 16'd127);

    // Randomized traffic against the model
    s_lvl = 1'b0;
    d_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 59) == 0) d_lvl = ~d_lvl;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), s_lvl, d_lvl);
      chk("excl", 16'(tick && time_out), 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
